// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples SCK/NSS/MOSI in the clk_i domain and exchanges
// 8/16/24/32-bit words with the register/FIFO layer over valid/ready handshakes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | NSS high or frame not yet started; waiting for NSS fall
// LOAD   | one cycle: first tx word taken, MISO driven with bit 0 (CPHA=0)
// ACTIVE | frame running; SCK edges shift data in and out
// HOLD   | NSS fell while disabled; ignore the frame until NSS rises
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  trl_i,
  input  logic        clr_i,
  output logic        busy_o,
  output logic        ovr_o,
  output logic        udr_o,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] nss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_s, nss_s, mosi_s;
  logic sck_prev, nss_prev;

  logic        sck_edge, lead_edge, trail_edge, act;
  logic        sample_stb, shift_stb, last_bit, word_done, load_stb, nss_fall;
  logic [4:0]  bit_cnt, last_idx, bit_idx, first_idx;
  logic [31:0] tx_word, load_word, rx_acc, rx_next;

  // Input synchronizers; reset values match an idle, deselected bus
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      nss_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev  <= sck_s;
      nss_prev  <= nss_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign nss_s  = nss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign nss_fall   = nss_prev & ~nss_s;
  assign sck_edge   = sck_s ^ sck_prev;
  assign lead_edge  = sck_edge & (sck_prev == cpol_i);
  assign trail_edge = sck_edge & (sck_prev != cpol_i);
  assign act        = (state == ST_ACTIVE) & ~nss_s;
  assign sample_stb = act & (cpha_i ? trail_edge : lead_edge);
  assign shift_stb  = act & (cpha_i ? lead_edge : trail_edge);

  // Bit k maps to data[len-1-k] MSB-first, data[k] LSB-first, for tx and rx alike
  assign last_idx  = {trl_i, 3'b111};
  assign last_bit  = (bit_cnt == last_idx);
  assign word_done = sample_stb & last_bit;
  assign load_stb  = (state == ST_LOAD) | word_done;
  assign bit_idx   = lsb_i ? bit_cnt : (last_idx - bit_cnt);
  assign first_idx = lsb_i ? 5'd0 : last_idx;
  assign load_word = tx_valid_i ? tx_data_i : 32'hFFFF_FFFF;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (nss_fall) begin
          state_nxt = en_i ? ST_LOAD : ST_HOLD;
        end
      end
      ST_LOAD:   state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (nss_s) state_nxt = ST_IDLE;
      ST_HOLD:   if (nss_s) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_miso_en_o = 1'b0;
    tx_ready_o    = 1'b0;
    if ((state == ST_LOAD) || (state == ST_ACTIVE)) begin
      spi_miso_en_o = 1'b1;
    end
    if (load_stb) begin
      tx_ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt <= '0;
    end else if (state != ST_ACTIVE) begin
      bit_cnt <= '0;
    end else if (sample_stb) begin
      bit_cnt <= last_bit ? 5'd0 : (bit_cnt + 5'd1);
    end
  end

  // MISO only moves at LOAD (CPHA=0) and on shift edges; the next word is
  // already in tx_word by the shift edge that follows the last sample edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_word    <= '0;
      spi_miso_o <= 1'b0;
    end else begin
      if (load_stb) begin
        tx_word <= load_word;
      end
      if ((state == ST_LOAD) && !cpha_i) begin
        spi_miso_o <= load_word[first_idx];
      end else if (shift_stb) begin
        spi_miso_o <= tx_word[bit_idx];
      end
    end
  end

  always_comb begin
    rx_next          = rx_acc;
    rx_next[bit_idx] = mosi_s;
  end

  // Partial words are dropped whenever the frame leaves ACTIVE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_acc <= '0;
    end else if (state != ST_ACTIVE) begin
      rx_acc <= '0;
    end else if (sample_stb) begin
      rx_acc <= last_bit ? 32'h0 : rx_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      if (word_done) begin
        rx_data_o  <= rx_next;
        rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  // A flag set in the same cycle as clr_i wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovr_o <= 1'b0;
      udr_o <= 1'b0;
    end else begin
      if (word_done && rx_valid_o && !rx_ready_i) begin
        ovr_o <= 1'b1;
      end else if (clr_i) begin
        ovr_o <= 1'b0;
      end
      if (load_stb && !tx_valid_i) begin
        udr_o <= 1'b1;
      end else if (clr_i) begin
        udr_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
    end else begin
      busy_o <= ~nss_s;
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: a behavioural SPI master plus tx/rx
// word queues; expected words come from the master-side view of each frame.
module tb_spi_slave_core;

  localparam int SYNC = 2;
  localparam int HP   = 10;

  logic        clk_i, rst_i, en_i, cpol_i, cpha_i, lsb_i, clr_i;
  logic [1:0]  trl_i;
  logic        busy_o, ovr_o, udr_o;
  logic        tx_valid_i, tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o, rx_ready_i;
  logic [31:0] rx_data_o;
  logic        spi_sck_i, spi_nss_i, spi_mosi_i, spi_miso_o, spi_miso_en_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  int          tx_hs_cnt = 0;
  int          tx_ready_cnt = 0;
  logic        miso_en_seen = 1'b0;
  logic        prov_hs;
  logic [31:0] mw[4];
  logic [31:0] sw[4];

  spi_slave_core #(.SYNC_STAGES(SYNC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .cpol_i(cpol_i), .cpha_i(cpha_i),
    .lsb_i(lsb_i), .trl_i(trl_i), .clr_i(clr_i), .busy_o(busy_o), .ovr_o(ovr_o),
    .udr_o(udr_o), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_data_o(rx_data_o), .spi_sck_i(spi_sck_i), .spi_nss_i(spi_nss_i),
    .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // tx word source: presents the queue head, pops it on each handshake
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 32'h0;
    forever begin
      @(negedge clk_i);
      prov_hs = tx_ready_o && tx_valid_i;
      @(posedge clk_i);
      #1;
      if (prov_hs) begin
        tx_hs_cnt++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      tx_valid_i = (tx_q.size() > 0);
      tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (rx_valid_o && rx_ready_i) rx_q.push_back(rx_data_o);
      if (spi_miso_en_o) miso_en_seen = 1'b1;
      if (tx_ready_o) tx_ready_cnt++;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] len_mask();
    int len;
    len = 8 * (int'(trl_i) + 1);
    return (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
  endfunction

  task automatic clear_flags();
    clr_i = 1'b1;
    wait_cyc(1);
    clr_i = 1'b0;
    wait_cyc(1);
  endtask

  // Master: sends mw[] and assembles what it sees on MISO into sw[]
  task automatic spi_xfer(input int nwords, input int nbits_ovr, input bit hold);
    int len, nbits, w, k;
    logic bitv;
    len   = 8 * (int'(trl_i) + 1);
    nbits = (nbits_ovr > 0) ? nbits_ovr : nwords * len;
    for (int i = 0; i < 4; i++) sw[i] = 32'h0;
    spi_sck_i = cpol_i;
    wait_cyc(HP);
    spi_nss_i = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      w = b / len;
      k = b % len;
      bitv = lsb_i ? mw[w][k] : mw[w][len-1-k];
      if (!cpha_i) begin
        spi_mosi_i = bitv;
        wait_cyc(HP);
        if (lsb_i) sw[w][k] = spi_miso_o; else sw[w][len-1-k] = spi_miso_o;
        spi_sck_i = ~cpol_i;
        wait_cyc(HP);
        spi_sck_i = cpol_i;
      end else begin
        wait_cyc(HP);
        spi_sck_i  = ~cpol_i;
        spi_mosi_i = bitv;
        wait_cyc(HP);
        if (lsb_i) sw[w][k] = spi_miso_o; else sw[w][len-1-k] = spi_miso_o;
        spi_sck_i = cpol_i;
      end
    end
    wait_cyc(HP);
    if (!hold) begin
      spi_nss_i = 1'b1;
      wait_cyc(2 * HP);
    end
  endtask

  task automatic test_reset();
    wait_cyc(3);
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (tx_ready_o !== 1'b0) begin failures++; $display("FAIL rst_tx_ready got=%b exp=0", tx_ready_o); end
    checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid_o); end
    checks++; if (rx_data_o !== 32'h0) begin failures++; $display("FAIL rst_rx_data got=%h exp=0", rx_data_o); end
    checks++; if (spi_miso_o !== 1'b0) begin failures++; $display("FAIL rst_miso got=%b exp=0", spi_miso_o); end
    checks++; if (spi_miso_en_o !== 1'b0) begin failures++; $display("FAIL rst_miso_en got=%b exp=0", spi_miso_en_o); end
    checks++; if (ovr_o !== 1'b0) begin failures++; $display("FAIL rst_ovr got=%b exp=0", ovr_o); end
    checks++; if (udr_o !== 1'b0) begin failures++; $display("FAIL rst_udr got=%b exp=0", udr_o); end
    rst_i = 1'b0;
    wait_cyc(5);
    checks++; if ({busy_o, spi_miso_en_o, tx_ready_o} !== 3'b000) begin
      failures++; $display("FAIL post_rst_idle got=%b exp=000", {busy_o, spi_miso_en_o, tx_ready_o});
    end
  endtask

  task automatic test_mode0_msb8();
    int hs0;
    cpol_i = 0; cpha_i = 0; lsb_i = 0; trl_i = 2'd0; rx_ready_i = 1;
    rx_q.delete();
    tx_q.push_back(32'h0000_00A5);
    mw[0] = 32'h3C;
    hs0 = tx_hs_cnt;
    spi_xfer(1, 0, 0);
    checks++; if (sw[0] !== 32'hA5) begin failures++; $display("FAIL mode0_miso got=%h exp=a5", sw[0]); end
    checks++; if (rx_q.size() !== 1) begin failures++; $display("FAIL mode0_rx_count got=%0d exp=1", rx_q.size()); end
    else begin
      checks++; if (rx_q[0] !== 32'h0000_003C) begin failures++; $display("FAIL mode0_rx_data got=%h exp=0000003c", rx_q[0]); end
    end
    checks++; if (tx_hs_cnt - hs0 !== 1) begin failures++; $display("FAIL mode0_tx_hs got=%0d exp=1", tx_hs_cnt - hs0); end
    checks++; if (ovr_o !== 1'b0) begin failures++; $display("FAIL mode0_ovr got=%b exp=0", ovr_o); end
    clear_flags();
  endtask

  task automatic test_mode3_lsb32();
    cpol_i = 1; cpha_i = 1; lsb_i = 1; trl_i = 2'd3; rx_ready_i = 1;
    rx_q.delete();
    tx_q.push_back(32'h1234_5678);
    mw[0] = 32'hDEAD_BEEF;
    spi_xfer(1, 0, 0);
    checks++; if (sw[0] !== 32'h1234_5678) begin failures++; $display("FAIL mode3_miso got=%h exp=12345678", sw[0]); end
    checks++; if ((rx_q.size() != 1) || (rx_q[0] !== 32'hDEAD_BEEF)) begin
      failures++; $display("FAIL mode3_rx got=%h n=%0d exp=deadbeef", (rx_q.size() > 0) ? rx_q[0] : 32'h0, rx_q.size());
    end
    clear_flags();
  endtask

  task automatic test_modes12_flags();
    logic [31:0] t0, t1;
    int hs0;
    for (int m = 1; m <= 2; m++) begin
      cpol_i = (m == 2); cpha_i = (m == 1); lsb_i = 0; trl_i = 2'd1; rx_ready_i = 0;
      clear_flags();
      t0 = $urandom & 32'hFFFF;
      t1 = $urandom & 32'hFFFF;
      tx_q.push_back(t0);
      tx_q.push_back(t1);
      for (int i = 0; i < 3; i++) mw[i] = $urandom & 32'hFFFF;
      hs0 = tx_hs_cnt;
      spi_xfer(3, 0, 0);
      checks++; if (sw[0] !== t0) begin failures++; $display("FAIL m%0d_w0 got=%h exp=%h", m, sw[0], t0); end
      checks++; if (sw[1] !== t1) begin failures++; $display("FAIL m%0d_w1 got=%h exp=%h", m, sw[1], t1); end
      checks++; if (sw[2] !== 32'hFFFF) begin failures++; $display("FAIL m%0d_w2_udr got=%h exp=ffff", m, sw[2]); end
      checks++; if (tx_hs_cnt - hs0 !== 2) begin failures++; $display("FAIL m%0d_tx_hs got=%0d exp=2", m, tx_hs_cnt - hs0); end
      checks++; if (udr_o !== 1'b1) begin failures++; $display("FAIL m%0d_udr got=%b exp=1", m, udr_o); end
      checks++; if (ovr_o !== 1'b1) begin failures++; $display("FAIL m%0d_ovr got=%b exp=1", m, ovr_o); end
      checks++; if ({rx_valid_o, rx_data_o} !== {1'b1, mw[2]}) begin
        failures++; $display("FAIL m%0d_rx_hold got=%b/%h exp=1/%h", m, rx_valid_o, rx_data_o, mw[2]);
      end
      clear_flags();
      checks++; if ({ovr_o, udr_o} !== 2'b00) begin failures++; $display("FAIL m%0d_clr got=%b exp=00", m, {ovr_o, udr_o}); end
      rx_ready_i = 1;
      wait_cyc(3);
      checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL m%0d_rx_drain got=%b exp=0", m, rx_valid_o); end
      rx_q.delete();
    end
  endtask

  task automatic test_nss_abort();
    int hs0;
    cpol_i = 0; cpha_i = 0; lsb_i = 0; trl_i = 2'd0; rx_ready_i = 1;
    rx_q.delete();
    tx_q.push_back(32'h5A);
    mw[0] = $urandom & 32'hFF;
    hs0 = tx_hs_cnt;
    spi_xfer(1, 5, 1);
    checks++; if ({busy_o, spi_miso_en_o} !== 2'b11) begin failures++; $display("FAIL abort_pre got=%b exp=11", {busy_o, spi_miso_en_o}); end
    spi_nss_i = 1'b1;
    wait_cyc(SYNC + 2);
    checks++; if ({busy_o, spi_miso_en_o} !== 2'b00) begin failures++; $display("FAIL abort_fall got=%b exp=00", {busy_o, spi_miso_en_o}); end
    wait_cyc(2 * HP);
    checks++; if ((rx_q.size() != 0) || (rx_valid_o !== 1'b0)) begin
      failures++; $display("FAIL abort_no_rx got=%0d/%b exp=0/0", rx_q.size(), rx_valid_o);
    end
    checks++; if (tx_hs_cnt - hs0 !== 1) begin failures++; $display("FAIL abort_tx_hs got=%0d exp=1", tx_hs_cnt - hs0); end
    tx_q.push_back(32'hC3);
    mw[0] = $urandom & 32'hFF;
    spi_xfer(1, 0, 0);
    checks++; if (sw[0] !== 32'hC3) begin failures++; $display("FAIL abort_next_miso got=%h exp=c3", sw[0]); end
    checks++; if ((rx_q.size() != 1) || (rx_q[0] !== mw[0])) begin
      failures++; $display("FAIL abort_next_rx got=%h n=%0d exp=%h", (rx_q.size() > 0) ? rx_q[0] : 32'h0, rx_q.size(), mw[0]);
    end
    clear_flags();
  endtask

  task automatic test_en_off();
    int rdy0;
    cpol_i = 0; cpha_i = 0; lsb_i = 0; trl_i = 2'd0; rx_ready_i = 1;
    en_i = 0;
    rx_q.delete();
    tx_q.push_back(32'h77);
    mw[0] = 32'h81;
    wait_cyc(2);
    miso_en_seen = 1'b0;
    rdy0 = tx_ready_cnt;
    spi_xfer(1, 0, 0);
    checks++; if (miso_en_seen !== 1'b0) begin failures++; $display("FAIL en_off_miso_en got=%b exp=0", miso_en_seen); end
    checks++; if (tx_ready_cnt - rdy0 !== 0) begin failures++; $display("FAIL en_off_tx_ready got=%0d exp=0", tx_ready_cnt - rdy0); end
    checks++; if (rx_q.size() !== 0) begin failures++; $display("FAIL en_off_rx got=%0d exp=0", rx_q.size()); end
    en_i = 1;
    tx_q.delete();
    wait_cyc(2);
  endtask

  task automatic test_random();
    int nw, s, hs0;
    logic [31:0] tw[4];
    logic [31:0] exp;
    for (int it = 0; it < 8; it++) begin
      cpol_i = 1'($urandom_range(0, 1));
      cpha_i = 1'($urandom_range(0, 1));
      lsb_i  = 1'($urandom_range(0, 1));
      trl_i  = 2'($urandom_range(0, 3));
      rx_ready_i = 1;
      rx_q.delete();
      nw = $urandom_range(1, 3);
      s  = ($urandom_range(0, 1) == 1) ? nw : nw - 1;
      for (int i = 0; i < 4; i++) begin
        tw[i] = $urandom;
        mw[i] = $urandom;
      end
      for (int i = 0; i < s; i++) tx_q.push_back(tw[i]);
      hs0 = tx_hs_cnt;
      spi_xfer(nw, 0, 0);
      for (int i = 0; i < nw; i++) begin
        exp = ((i < s) ? tw[i] : 32'hFFFF_FFFF) & len_mask();
        checks++; if (sw[i] !== exp) begin failures++; $display("FAIL rand%0d_miso%0d got=%h exp=%h", it, i, sw[i], exp); end
      end
      checks++; if (rx_q.size() !== nw) begin failures++; $display("FAIL rand%0d_rx_count got=%0d exp=%0d", it, rx_q.size(), nw); end
      else begin
        for (int i = 0; i < nw; i++) begin
          exp = mw[i] & len_mask();
          checks++; if (rx_q[i] !== exp) begin failures++; $display("FAIL rand%0d_rx%0d got=%h exp=%h", it, i, rx_q[i], exp); end
        end
      end
      checks++; if (tx_hs_cnt - hs0 !== s) begin failures++; $display("FAIL rand%0d_tx_hs got=%0d exp=%0d", it, tx_hs_cnt - hs0, s); end
      clear_flags();
    end
  endtask

  task automatic test_reset_mid_frame();
    cpol_i = 0; cpha_i = 0; lsb_i = 0; trl_i = 2'd0; rx_ready_i = 0;
    rx_q.delete();
    tx_q.push_back(32'hFF);
    mw[0] = 32'hA7;
    spi_xfer(1, 0, 1);
    checks++; if ({busy_o, spi_miso_en_o, rx_valid_o, spi_miso_o} !== 4'b1111) begin
      failures++; $display("FAIL midrst_pre got=%b exp=1111", {busy_o, spi_miso_en_o, rx_valid_o, spi_miso_o});
    end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
    checks++; if (spi_miso_en_o !== 1'b0) begin failures++; $display("FAIL midrst_miso_en got=%b exp=0", spi_miso_en_o); end
    checks++; if (spi_miso_o !== 1'b0) begin failures++; $display("FAIL midrst_miso got=%b exp=0", spi_miso_o); end
    checks++; if (rx_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got=%b exp=0", rx_valid_o); end
    checks++; if (rx_data_o !== 32'h0) begin failures++; $display("FAIL midrst_rx_data got=%h exp=0", rx_data_o); end
    checks++; if ({ovr_o, udr_o, tx_ready_o} !== 3'b000) begin
      failures++; $display("FAIL midrst_flags got=%b exp=000", {ovr_o, udr_o, tx_ready_o});
    end
    spi_nss_i = 1'b1;
    wait_cyc(4);
    rst_i = 1'b0;
    tx_q.delete();
    wait_cyc(4);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b1; cpol_i = 0; cpha_i = 0; lsb_i = 0; trl_i = 2'd0;
    clr_i = 1'b0; rx_ready_i = 1'b1;
    spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
    test_reset();
    test_mode0_msb8();
    test_mode3_lsb32();
    test_modes12_flags();
    test_nss_abort();
    test_en_off();
    test_random();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
